adc_frame_accumulator: RTL and testbench

ADC_FRAME_ACCUMULATOR -- requirements
Module: adc_frame_accumulator

---
 rtl/adc_frame_accumulator.sv | 139 +++++++++++++
 tb/tb_adc_frame_accumulator.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_accumulator.sv
// adc_frame_accumulator: ping-pong frame buffer fed by two multi-channel ADCs.
// Each transfer stores one sample per channel; full banks are handed to a reader.
module adc_frame_accumulator #(
  parameter int CH_PER_ADC = 4,
  parameter int IN_W       = 32,
  parameter int SAMPLE_W   = 22,
  parameter int DEPTH      = 512,
  parameter int SAT_MODE   = 0,
  localparam int NCH   = 2 * CH_PER_ADC,
  localparam int CH_W  = $clog2(NCH),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CH_PER_ADC-1:0][IN_W-1:0]  mat_a,
  input  logic [CH_PER_ADC-1:0][IN_W-1:0]  mat_b,
  output logic                             frame_ready,
  input  logic                             frame_release,
  output logic                             frame_done,
  output logic [15:0]                      frame_count,
  input  logic                             rd_en,
  input  logic [CH_W-1:0]                  rd_ch,
  input  logic [IDX_W-1:0]                 rd_idx,
  output logic [SAMPLE_W-1:0]              rd_data
);

  logic [SAMPLE_W-1:0] mem [2][NCH][DEPTH];

  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [1:0]          bank_full_q, bank_full_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                frame_done_q, frame_done_d;
  logic [SAMPLE_W-1:0] rd_data_q, rd_data_d;

  logic xfer;
  logic last;
  logic rel;
  logic [NCH-1:0][SAMPLE_W-1:0] wr_word;

  // Out-of-range words clamp to the extreme of their own sign.
  function automatic logic [SAMPLE_W-1:0] conv(
    input logic [IN_W-1:0] w
  );
    logic [IN_W-SAMPLE_W:0] top;
    top  = w[IN_W-1:SAMPLE_W-1];
    conv = w[SAMPLE_W-1:0];
    if (SAT_MODE != 0 && !(&top) && (|top)) begin
      conv = {w[IN_W-1], {(SAMPLE_W-1){~w[IN_W-1]}}};
    end
  endfunction

  always_comb begin
    wr_word = '0;
    for (int i = 0; i < CH_PER_ADC; i++) begin
      wr_word[i]              = conv(mat_a[i]);
      wr_word[CH_PER_ADC + i] = conv(mat_b[i]);
    end
  end

  assign in_ready    = ~bank_full_q[wr_bank_q];
  assign frame_ready = bank_full_q[rd_bank_q];
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign rd_data     = rd_data_q;

  assign xfer = in_valid & in_ready;
  assign last = xfer & (wr_idx_q == IDX_W'(DEPTH - 1));
  assign rel  = frame_release & frame_ready;

  always_comb begin
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_idx_d      = wr_idx_q;
    bank_full_d   = bank_full_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    rd_data_d     = rd_data_q;

    if (xfer) begin
      wr_idx_d = wr_idx_q + 1'b1;
    end

    // A completing frame and a release always touch different banks.
    if (last) begin
      bank_full_d[wr_bank_q] = 1'b1;
      wr_bank_d              = ~wr_bank_q;
      wr_idx_d               = '0;
      frame_count_d          = frame_count_q + 16'd1;
      frame_done_d           = 1'b1;
    end

    if (rel) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end

    if (rd_en) begin
      if (int'(rd_ch) < NCH) begin
        rd_data_d = mem[rd_bank_q][rd_ch][rd_idx];
      end else begin
        rd_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      bank_full_q   <= 2'b00;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_idx_q      <= wr_idx_d;
      bank_full_q   <= bank_full_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      for (int c = 0; c < NCH; c++) begin
        mem[wr_bank_q][c][wr_idx_q] <= wr_word[c];
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_accumulator.sv
// tb_adc_frame_accumulator: directed and random checks of the ping-pong
// frame accumulator against a frame-level queue model.
module tb_adc_frame_accumulator;

  localparam int CH    = 4;
  localparam int NCH   = 8;
  localparam int IN_W  = 32;
  localparam int SW    = 22;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [CH-1:0][IN_W-1:0]  mat_a = '0;
  logic [CH-1:0][IN_W-1:0]  mat_b = '0;
  logic                     frame_ready;
  logic                     frame_release = 1'b0;
  logic                     frame_done;
  logic [15:0]              frame_count;
  logic                     rd_en = 1'b0;
  logic [2:0]               rd_ch = '0;
  logic [2:0]               rd_idx = '0;
  logic [SW-1:0]            rd_data;

  adc_frame_accumulator #(
    .CH_PER_ADC(CH), .IN_W(IN_W), .SAMPLE_W(SW),
    .DEPTH(DEPTH), .SAT_MODE(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mat_a(mat_a), .mat_b(mat_b),
    .frame_ready(frame_ready), .frame_release(frame_release),
    .frame_done(frame_done), .frame_count(frame_count),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_idx(rd_idx),
    .rd_data(rd_data)
  );

  logic                    s_in_valid = 1'b0;
  logic                    s_in_ready;
  logic [2:0][IN_W-1:0]    s_mat_a = '0;
  logic [2:0][IN_W-1:0]    s_mat_b = '0;
  logic                    s_frame_ready;
  logic                    s_frame_release = 1'b0;
  logic                    s_frame_done;
  logic [15:0]             s_frame_count;
  logic                    s_rd_en = 1'b0;
  logic [2:0]              s_rd_ch = '0;
  logic [0:0]              s_rd_idx = '0;
  logic [SW-1:0]           s_rd_data;

  adc_frame_accumulator #(
    .CH_PER_ADC(3), .IN_W(IN_W), .SAMPLE_W(SW),
    .DEPTH(2), .SAT_MODE(1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .mat_a(s_mat_a), .mat_b(s_mat_b),
    .frame_ready(s_frame_ready), .frame_release(s_frame_release),
    .frame_done(s_frame_done), .frame_count(s_frame_count),
    .rd_en(s_rd_en), .rd_ch(s_rd_ch), .rd_idx(s_rd_idx),
    .rd_data(s_rd_data)
  );

  int checks   = 0;
  int failures = 0;

  logic [SW-1:0] m_mem   [2][NCH][DEPTH];
  bit            m_known [2][NCH][DEPTH];
  int            full_q[$];
  int            m_wr_bank;
  int            m_wr_idx;
  int            m_count;
  bit            m_done;
  logic [SW-1:0] m_rd;
  bit            m_rd_known;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    full_q.delete();
    m_wr_bank  = 0;
    m_wr_idx   = 0;
    m_count    = 0;
    m_done     = 0;
    m_rd       = '0;
    m_rd_known = 1;
  endtask

  task automatic set_data(input int k);
    for (int i = 0; i < CH; i++) begin
      mat_a[i] = 32'(16 * k + i);
      mat_b[i] = 32'(16 * k + 4 + i);
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < CH; i++) begin
      mat_a[i] = $urandom;
      mat_b[i] = $urandom;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic cyc(input bit v, input bit rel, input bit re,
                     input int ch, input int idx);
    bit rdy;
    bit xfer;
    bit frel;
    int rb;
    logic [IN_W-1:0] word;
    in_valid      = v;
    frame_release = rel;
    rd_en         = re;
    rd_ch         = ch[2:0];
    rd_idx        = idx[2:0];
    rdy  = full_q.size() < 2;
    chk("in_ready_pre", in_ready, 32'(rdy));
    rb   = (full_q.size() > 0) ? full_q[0] : m_wr_bank;
    xfer = v && rdy;
    frel = rel && full_q.size() > 0;
    if (re) begin
      m_rd       = m_mem[rb][ch][idx];
      m_rd_known = m_known[rb][ch][idx];
    end
    m_done = 0;
    if (frel) void'(full_q.pop_front());
    if (xfer) begin
      for (int c = 0; c < NCH; c++) begin
        word = (c < CH) ? mat_a[c] : mat_b[c - CH];
        m_mem[m_wr_bank][c][m_wr_idx]   = word[SW-1:0];
        m_known[m_wr_bank][c][m_wr_idx] = 1;
      end
      if (m_wr_idx == DEPTH - 1) begin
        full_q.push_back(m_wr_bank);
        m_wr_bank = 1 - m_wr_bank;
        m_wr_idx  = 0;
        m_count   = (m_count + 1) % 65536;
        m_done    = 1;
      end else begin
        m_wr_idx++;
      end
    end
    @(posedge clk);
    #1;
    chk("frame_done", frame_done, 32'(m_done));
    chk("frame_ready", frame_ready, 32'(full_q.size() > 0));
    chk("frame_count", frame_count, 32'(m_count));
    chk("in_ready_post", in_ready, 32'(full_q.size() < 2));
    if (m_rd_known) chk("rd_data", rd_data, m_rd);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_frame_ready"}, frame_ready, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
  endtask

  // Asserts reset between edges so its effect is seen without a clock.
  task automatic do_reset(input string tag);
    in_valid      = 0;
    frame_release = 0;
    rd_en         = 0;
    rst_n         = 0;
    #2;
    chk_reset_outs(tag);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic s_read(input int ch, input logic [31:0] exp,
                        input string tag);
    s_rd_en  = 1;
    s_rd_ch  = ch[2:0];
    s_rd_idx = '0;
    @(posedge clk);
    #1;
    s_rd_en = 0;
    chk(tag, s_rd_data, exp);
  endtask

  initial begin
    #1;
    rst_n = 0;
    #3;
    chk_reset_outs("por");
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();

    // Full frame with the reference pattern, then a readback.
    for (int k = 0; k < DEPTH; k++) begin
      set_data(k);
      cyc(1, 0, 0, 0, 0);
    end
    chk("f1_count", frame_count, 1);
    cyc(0, 0, 1, 5, 3);
    chk("f1_rd_c5_i3", rd_data, 32'h35);
    idle();
    chk("rd_hold", rd_data, 32'h35);

    // Truncation of extreme words, read from a not-yet-full bank.
    mat_a[0] = 32'h7FFFFFFF;
    mat_a[1] = 32'h80000000;
    mat_a[2] = 32'hFFFFFFFF;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("trunc_7fff", rd_data, 32'h3FFFFF);
    cyc(0, 0, 1, 1, 0);
    chk("trunc_8000", rd_data, 32'h0);
    cyc(0, 0, 1, 2, 0);
    chk("trunc_ffff", rd_data, 32'h3FFFFF);

    // Release bank 0 in the same cycle bank 1 completes.
    do_reset("rst2");
    for (int k = 0; k < 2 * DEPTH - 1; k++) begin
      set_data(k);
      cyc(1, 0, 0, 0, 0);
    end
    set_data(15);
    cyc(1, 1, 0, 0, 0);
    chk("same_cyc_ready", frame_ready, 1);
    chk("same_cyc_count", frame_count, 2);
    chk("same_cyc_in_ready", in_ready, 1);
    cyc(0, 0, 1, 2, 7);
    chk("same_cyc_rd_bank1", rd_data, 32'hF2);

    // Back-to-back input with no release stalls after two frames.
    do_reset("rst3");
    for (int k = 0; k < 24; k++) begin
      set_data(k);
      cyc(1, 0, 0, 0, 0);
    end
    chk("stall_in_ready", in_ready, 0);
    chk("stall_count", frame_count, 2);
    cyc(1, 1, 0, 0, 0);
    chk("resume_in_ready", in_ready, 1);
    set_data(50);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("resume_bank0", rd_data, 32'h320);

    // Reset mid-frame discards it; the next frame starts at index 0.
    do_reset("rst4");
    for (int k = 0; k < 5; k++) begin
      set_data(k + 60);
      cyc(1, 0, 0, 0, 0);
    end
    do_reset("rst_mid");
    for (int k = 0; k < DEPTH; k++) begin
      set_data(k + 100);
      cyc(1, 0, 0, 0, 0);
    end
    chk("post_rst_count", frame_count, 1);
    for (int k = 0; k < DEPTH; k++) begin
      cyc(0, 0, 1, 0, k);
      chk("post_rst_idx", rd_data, 32'(16 * (k + 100)));
    end

    // Release with nothing ready changes nothing.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("noop_release_ready", frame_ready, 0);

    // Random traffic against the frame model.
    for (int n = 0; n < 400; n++) begin
      set_rand();
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
          $urandom_range(0, 1) == 1,
          int'($urandom_range(0, NCH - 1)),
          int'($urandom_range(0, DEPTH - 1)));
    end

    // Saturating instance: six channels, depth two.
    do_reset("rst5");
    s_mat_a[0] = 32'h7FFFFFFF;
    s_mat_a[1] = 32'h80000000;
    s_mat_a[2] = 32'hFFFFFFFF;
    s_mat_b[0] = 32'h00000123;
    s_in_valid = 1;
    @(posedge clk);
    #1;
    s_in_valid = 0;
    chk("sat_in_ready", s_in_ready, 1);
    chk("sat_frame_ready", s_frame_ready, 0);
    s_read(0, 32'h1FFFFF, "sat_pos");
    s_read(1, 32'h200000, "sat_neg");
    s_read(2, 32'h3FFFFF, "sat_minus1");
    s_read(3, 32'h123, "sat_small");
    s_frame_release = 1;
    @(posedge clk);
    #1;
    s_frame_release = 0;
    chk("sat_noop_rel_ready", s_frame_ready, 0);
    chk("sat_noop_rel_count", s_frame_count, 0);
    s_read(7, 32'h0, "sat_rd_ch_oob");
    s_read(3, 32'h123, "sat_after_noop");
    s_in_valid = 1;
    @(posedge clk);
    #1;
    s_in_valid = 0;
    chk("sat_done", s_frame_done, 1);
    chk("sat_count", s_frame_count, 1);
    chk("sat_ready", s_frame_ready, 1);
    @(posedge clk);
    #1;
    chk("sat_done_pulse", s_frame_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
